// File: rtl/mips_pkg.sv
// Shared PCSrc encodings and vector addresses for the control decoder and the PC stage.
// Vectors sit in the kernel half of the address space (bit 31 set).
package mips_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;
  localparam logic [2:0] PCSRC_IRQ = 3'd4;
  localparam logic [2:0] PCSRC_EXC = 3'd5;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pc_unit_irq_sync.sv
// Two-flop synchroniser plus history flop for the async timer request; one-cycle pulse per rising edge.
// Pulse appears two edges after irq_in is first sampled high; a held-high input does not re-pulse.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pc_unit.sv
// PC register and next-PC select; PC updates one edge after the select inputs, pc_en=0 stalls.
// Latches the synchronised timer interrupt and masks it while the PC is in kernel space.
module pc_unit #(
  parameter logic [31:0] RESET_VEC = mips_pkg::RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = mips_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC   = mips_pkg::EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        ALUOut0,
  input  logic [31:0] Imm32,
  input  logic [25:0] JT,
  input  logic [31:0] RsData,
  input  logic        pc_en,
  input  logic        irq_in,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] ReturnAddr,
  output logic        ker,
  output logic        IRQ
);
  import mips_pkg::*;

  logic [31:0] pc_nxt;
  logic [31:0] br_tgt;
  logic        pending;
  logic        rise;
  logic        unused_imm;

  // Only the low 29 immediate bits survive the <<2 into a 31-bit offset.
  assign unused_imm = ^Imm32[31:29];

  // The kernel bit is never produced by sequential or branch arithmetic.
  assign PC_plus4 = {PC[31], PC[30:0] + 31'd4};
  assign br_tgt   = {PC[31], PC_plus4[30:0] + {Imm32[28:0], 2'b00}};

  always_comb begin
    pc_nxt = PC_plus4;
    case (PCSrc)
      PCSRC_BR:  if (ALUOut0) pc_nxt = br_tgt;
      PCSRC_J:   pc_nxt = {PC_plus4[31:28], JT, 2'b00};
      PCSRC_JR:  pc_nxt = {PC[31] & RsData[31], RsData[30:0]};
      PCSRC_IRQ: pc_nxt = IRQ_VEC;
      PCSRC_EXC: pc_nxt = EXC_VEC;
      default:   pc_nxt = PC_plus4;
    endcase
  end

  // The interrupted instruction never executed, so the handler returns to it.
  assign ReturnAddr = (PCSrc == PCSRC_IRQ) ? PC : PC_plus4;
  assign ker        = PC[31];
  assign IRQ        = pending & ~ker;

  always_ff @(posedge clk) begin
    if (reset)      PC <= RESET_VEC;
    else if (pc_en) PC <= pc_nxt;
  end

  irq_sync u_irq_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .rise   (rise)
  );

  // A new edge wins over acknowledgement so a back-to-back request is not lost.
  always_ff @(posedge clk) begin
    if (reset)
      pending <= 1'b0;
    else if (rise)
      pending <= 1'b1;
    else if (pc_en && (PCSrc == PCSRC_IRQ))
      pending <= 1'b0;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus queues expected post-edge outputs, a monitor pops and compares.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  PCSrc = 3'd0;
  logic        ALUOut0 = 1'b0;
  logic [31:0] Imm32 = 32'h0;
  logic [25:0] JT = 26'h0;
  logic [31:0] RsData = 32'h0;
  logic        pc_en = 1'b1;
  logic        irq_in = 1'b0;
  logic [31:0] PC, PC_plus4, ReturnAddr;
  logic        ker, IRQ;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic        irq;
    logic [31:0] ra;
    logic [31:0] p4;
    string       nm;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .ALUOut0    (ALUOut0),
    .Imm32      (Imm32),
    .JT         (JT),
    .RsData     (RsData),
    .pc_en      (pc_en),
    .irq_in     (irq_in),
    .PC         (PC),
    .PC_plus4   (PC_plus4),
    .ReturnAddr (ReturnAddr),
    .ker        (ker),
    .IRQ        (IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.nm, ".pc"},  PC, e.pc);
        chk({e.nm, ".ker"}, {31'd0, ker}, {31'd0, e.pc[31]});
        chk({e.nm, ".irq"}, {31'd0, IRQ}, {31'd0, e.irq});
        chk({e.nm, ".ra"},  ReturnAddr, e.ra);
        chk({e.nm, ".p4"},  PC_plus4, e.p4);
      end
    end
  end

  task automatic drive(input logic rst, input logic [2:0] src, input logic en, input logic irqi);
    @(negedge clk);
    reset  = rst;
    PCSrc  = src;
    pc_en  = en;
    irq_in = irqi;
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic irq, input logic [31:0] ra,
                            input logic [31:0] p4, input string nm);
    exp_t e;
    e.pc = pc; e.irq = irq; e.ra = ra; e.p4 = p4; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    drive(1, 0, 1, 0); expect_out(32'h8000_0000, 0, 32'h8000_0004, 32'h8000_0004, "reset");
    drive(0, 0, 1, 0); expect_out(32'h8000_0004, 0, 32'h8000_0008, 32'h8000_0008, "seq1");
    drive(0, 0, 1, 0); expect_out(32'h8000_0008, 0, 32'h8000_000C, 32'h8000_000C, "seq2");
    drive(0, 0, 1, 0); expect_out(32'h8000_000C, 0, 32'h8000_0010, 32'h8000_0010, "seq3");

    drive(0, 3, 1, 0); RsData = 32'h0000_0100;
    expect_out(32'h0000_0100, 0, 32'h0000_0104, 32'h0000_0104, "jr_user");
    drive(0, 1, 1, 0); Imm32 = 32'hFFFF_FFFE; ALUOut0 = 1'b1;
    expect_out(32'h0000_00FC, 0, 32'h0000_0100, 32'h0000_0100, "br_taken");
    drive(0, 3, 1, 0); RsData = 32'h0000_0100;
    expect_out(32'h0000_0100, 0, 32'h0000_0104, 32'h0000_0104, "jr_back");
    drive(0, 1, 1, 0); ALUOut0 = 1'b0;
    expect_out(32'h0000_0104, 0, 32'h0000_0108, 32'h0000_0108, "br_not");

    drive(0, 5, 1, 0); expect_out(32'h8000_0008, 0, 32'h8000_000C, 32'h8000_000C, "exc");
    drive(0, 3, 1, 0); RsData = 32'h0040_0000;
    expect_out(32'h0040_0000, 0, 32'h0040_0004, 32'h0040_0004, "jr_leave");
    drive(0, 3, 1, 0); RsData = 32'h8000_1000;
    expect_out(32'h0000_1000, 0, 32'h0000_1004, 32'h0000_1004, "jr_noenter");
    drive(0, 2, 1, 0); JT = 26'h010_0004;
    expect_out(32'h0040_0010, 0, 32'h0040_0014, 32'h0040_0014, "jump");

    // User-mode interrupt while stalled: IRQ appears at the third edge after irq_in rises.
    drive(0, 0, 0, 1); expect_out(32'h0040_0010, 0, 32'h0040_0014, 32'h0040_0014, "irq_n");
    drive(0, 0, 0, 1); expect_out(32'h0040_0010, 0, 32'h0040_0014, 32'h0040_0014, "irq_n1");
    drive(0, 0, 0, 1); expect_out(32'h0040_0010, 1, 32'h0040_0014, 32'h0040_0014, "irq_n2");
    drive(0, 4, 0, 1); expect_out(32'h0040_0010, 1, 32'h0040_0010, 32'h0040_0014, "stall_irq");
    drive(0, 4, 1, 1); expect_out(32'h8000_0004, 0, 32'h8000_0004, 32'h8000_0008, "take_irq");

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0); expect_out(32'h8000_0004, 0, 32'h8000_0008, 32'h8000_0008, "kflush");
    end
    drive(0, 0, 0, 1); expect_out(32'h8000_0004, 0, 32'h8000_0008, 32'h8000_0008, "kpulse");
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0); expect_out(32'h8000_0004, 0, 32'h8000_0008, 32'h8000_0008, "kmask");
    end
    drive(0, 3, 1, 0); RsData = 32'h0040_0000;
    expect_out(32'h0040_0000, 1, 32'h0040_0004, 32'h0040_0004, "jr_fire");

    drive(0, 4, 0, 0); expect_out(32'h0040_0000, 1, 32'h0040_0000, 32'h0040_0004, "stall_hold");
    drive(1, 4, 1, 0); expect_out(32'h8000_0000, 0, 32'h8000_0000, 32'h8000_0004, "mid_reset");
    drive(0, 3, 1, 0); RsData = 32'h0000_0040;
    expect_out(32'h0000_0040, 0, 32'h0000_0044, 32'h0000_0044, "post_reset");

    drive(0, 3, 1, 0); RsData = 32'h7FFF_FFFC;
    expect_out(32'h7FFF_FFFC, 0, 32'h0000_0000, 32'h0000_0000, "pre_wrap");
    drive(0, 0, 1, 0); expect_out(32'h0000_0000, 0, 32'h0000_0004, 32'h0000_0004, "wrap");
    drive(0, 6, 1, 0); expect_out(32'h0000_0004, 0, 32'h0000_0008, 32'h0000_0008, "src6");

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and next-PC stage of the single-cycle MIPS core. It sits directly downstream of the control decoder and consumes its `PCSrc` selection. It also sits upstream of that decoder, because it produces the `ker` (kernel-mode) and `IRQ` inputs the decoder needs. The block holds the PC register, computes the branch, jump, register and vector targets, synchronises and latches the external timer interrupt, and provides the return address written back on jal/jalr/interrupt/exception.

## Interface
Parameters:
- `RESET_VEC`, 32'h8000_0000: PC value after reset (kernel mode).
- `IRQ_VEC`, 32'h8000_0004: interrupt handler entry.
- `EXC_VEC`, 32'h8000_0008: exception handler entry.

Ports:
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `PCSrc`  in  3  next-PC select from the control decoder: 0 = PC+4, 1 = conditional branch, 2 = j/jal, 3 = jr/jalr, 4 = interrupt, 5 = exception, 6–7 = treated as 0.
- `ALUOut0`  in  1  branch condition, ALU result bit 0.
- `Imm32`  in  32  sign-extended 16-bit immediate.
- `JT`  in  26  jump target field `Instruction[25:0]`.
- `RsData`  in  32  register-file read of rs, used for jr/jalr.
- `pc_en`  in  1  PC update enable; low = stall.
- `irq_in`  in  1  asynchronous level interrupt request from the timer.
- `PC`  out  32  current PC.
- `PC_plus4`  out  32  sequential address, kernel bit preserved.
- `ReturnAddr`  out  32  value for the $ra / $26 writeback.
- `ker`  out  1  `PC[31]`.
- `IRQ`  out  1  pending interrupt, masked in kernel mode; drives the decoder's IRQ input.

## Operation
**PC+4 and the kernel bit**
- `PC_plus4 = {PC[31], PC[30:0] + 31'd4}`. The lower 31 bits wrap and never carry into bit 31.
- Example: user PC 32'h7FFF_FFFC gives `PC_plus4` = 32'h0000_0000.

**Next-PC selection** (registered only when `pc_en`=1):
- 0, 6, 7: `PC_plus4`.
- 1:
  - If `ALUOut0`=1: `{PC[31], (PC_plus4[30:0] + {Imm32[28:0],2'b00})}`. The branch target keeps the kernel bit.
  - Else `PC_plus4`.
- 2: `{PC_plus4[31:28], JT, 2'b00}`.
- 3: `{PC[31] & RsData[31], RsData[30:0]}`. jr can leave kernel mode but can never enter it.
- 4: `IRQ_VEC`.
- 5: `EXC_VEC`.

**Return address**
- `ReturnAddr` = `PC` when `PCSrc`=4. The interrupted instruction was not executed, so the handler returns to it.
- Otherwise `ReturnAddr` = `PC_plus4`.

**Interrupt path**
- `irq_in` passes through a two-flop synchroniser (`s1`, `s2`) plus a history flop `s3`.
- A rising edge is `s2 & ~s3`.
- `pending` is set on a rising edge.
- `pending` is cleared on an edge where `PCSrc`=4 and `pc_en`=1.
- Set and clear in the same cycle: set wins, so `pending` stays 1.
- `IRQ = pending & ~ker`. A pending request is held while in kernel mode and fires after jr returns to user mode.

**Stall and reset**
- `pc_en`=0: `PC` holds, `pending` is not cleared, and the synchroniser and set logic keep running.
- Reset:
  - `PC` = `RESET_VEC`.
  - `s1`, `s2`, `s3` and `pending` = 0.
  - Outputs after reset: `PC`=32'h8000_0000, `ker`=1, `IRQ`=0, `PC_plus4`=32'h8000_0004, `ReturnAddr`=32'h8000_0004.
  - Reset asserted mid-operation overrides `pc_en` and any pending request on that edge.

## Timing
- `PC` updates one edge after `PCSrc`, `ALUOut0` and the target inputs are valid.
- `PC_plus4`, `ReturnAddr`, `ker` and `IRQ` are combinational from registers, and therefore valid in the same cycle as the state they depend on.
- IRQ latency: if `irq_in` is first sampled high at edge N, then `s1`=1 at N, `s2`=1 at N+1, and `pending`=1 at N+2. `IRQ` is visible from N+2 if in user mode.
- One interrupt per rising edge. A held-high `irq_in` does not re-trigger.

## Structure
- Shared package `mips_pkg`:
  - `PCSrc` encodings: `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JR`, `PCSRC_IRQ`, `PCSRC_EXC`.
  - Vector constants: `RESET_VEC`, `IRQ_VEC`, `EXC_VEC`.
  - These constants are shared with the control decoder.
- Sub-module `irq_sync`: the `s1`/`s2`/`s3` flops plus the rising-edge pulse output. Everything else stays inline.

## Test plan
- Reset then 3 edges with `PCSrc`=0 and `pc_en`=1 → `PC` = 8000_0000, 8000_0004, 8000_0008, 8000_000C; `ker`=1.
- At PC 0000_0100, `PCSrc`=1:
  - `Imm32`=FFFF_FFFE, `ALUOut0`=1 → `PC`=0000_00FC.
  - Same inputs with `ALUOut0`=0 → `PC`=0000_0104.
- jr from kernel, `RsData`=0040_0000 → `PC`=0040_0000, `ker`=0. Then jr with `RsData`=8000_1000 from user mode → `PC`=0000_1000, `ker` stays 0.
- User mode, `irq_in` raised → `IRQ`=1 two edges after the first sampling edge. Drive `PCSrc`=4 at PC 0040_0010 → `ReturnAddr`=0040_0010, next `PC`=8000_0004, `IRQ`=0.
- In kernel mode, `irq_in` pulses → `pending`=1 but `IRQ`=0. jr to 0040_0000 → `IRQ`=1 the same cycle `ker` falls.
- `pc_en`=0 with `PCSrc`=4 and `pending`=1 → `PC` holds and `pending` stays 1. Assert `reset` mid-stream → `PC`=8000_0000, `IRQ`=0.
- User PC 7FFF_FFFC, `PCSrc`=0 → `PC`=0000_0000, `ker`=0.
